ap_ctrl_hs_sequencer: RTL and testbench
=======================================

# ap_ctrl_hs_sequencer

Synthesizable transaction driver that sits directly upstream of the `ImgSharpeningFilter` top in the HLS co-simulation harness. It drives the DUT's `ap_ctrl_hs` block-level handshake (`ap_start`, `ap_continue`) for a programmed number of transactions. It timestamps each launch and completion, emits one latency record per completed transaction, and raises `finish` for the dataflow status monitor.

## Interface
Parameters:
- `CNT_W`, 32: width of the free-running cycle counter, timestamps and latency.
- `TS_DEPTH`, 4: start-timestamp FIFO depth; this is the maximum number of transactions in flight. Power of two, ≥ 2.
- `REC_DEPTH`, 8: record FIFO depth. Power of two, ≥ 2.

Ports (one clock; reset is asynchronous and active-low):
- `ap_clk` in 1: clock.
- `ap_rst_n` in 1: asynchronous active-low reset.
- `run` in 1: single-cycle request to begin a sequence.
- `trans_count` in 16: number of transactions; sampled when `run` is accepted.
- `dut_ap_start` out 1: to DUT `ap_start`.
- `dut_ap_ready` in 1: from DUT.
- `dut_ap_done` in 1: from DUT.
- `dut_ap_continue` out 1: to DUT `ap_continue`.
- `busy` out 1: high in `RUN` or `DRAIN`.
- `finish` out 1: high in `DONE`; feeds the monitor's `finish`.
- `rec_valid` out 1, `rec_ready` in 1: record stream handshake.
- `rec_index` out 16: transaction index, 0-based.
- `rec_start` out `CNT_W`: cycle of the start/ready handshake.
- `rec_latency` out `CNT_W`: done cycle minus start cycle.
- `err_unexpected_done` out 1: sticky error flag.

## Operation
- `cycle_cnt` is free-running from reset. It wraps modulo 2^`CNT_W`. `rec_latency` is computed modulo 2^`CNT_W`, so latency is correct across a wrap.
- States: `IDLE`, `RUN`, `DRAIN`, `DONE`.
- `IDLE` or `DONE` with `run`=1: latch `trans_count` into `total` and clear `issued`, `completed` and `err_unexpected_done`.
  - If `total`=0, go to `DONE`.
  - Otherwise go to `RUN`.
- `run` in `RUN` or `DRAIN` is ignored.
- Issue, in `RUN`:
  - `dut_ap_start` = (`issued` < `total`) && timestamp FIFO not full. It is a registered output.
  - An issue occurs on a cycle with `dut_ap_start` && `dut_ap_ready`. On an issue, push `cycle_cnt` into the timestamp FIFO and increment `issued`.
  - When `issued` reaches `total`, go to `DRAIN`. `dut_ap_start` drops in the same cycle as the state change.
- Completion, in `RUN` and `DRAIN`:
  - `dut_ap_continue` = record FIFO not full. This provides backpressure: the DUT stalls on `ap_done` until there is space.
  - A completion occurs on a cycle with `dut_ap_done` && `dut_ap_continue`.
  - On a completion, pop the timestamp FIFO. Push the record {`completed`, timestamp, `cycle_cnt` − timestamp} and increment `completed`.
- Simultaneous issue and completion in one cycle: both occur. The FIFO pushes and pops in the same cycle, and occupancy is unchanged.
- `dut_ap_done` while the timestamp FIFO is empty, or in `IDLE`/`DONE`: set `err_unexpected_done`, push no record, and leave counters unchanged.
- `DRAIN` → `DONE` when `completed` = `total` and the record FIFO is empty. `finish` is then high and held until the next accepted `run` or reset.
- Records are presented in completion order, which is also issue order under `ap_ctrl_hs`.

## Timing
- Reset (asynchronous, `ap_rst_n`=0) drives every output to 0. It also clears the state to `IDLE`, empties both FIFOs and zeroes all counters, including mid-sequence.
- `run` accepted at cycle t: `dut_ap_start`=1 from t+1.
- `dut_ap_start` stays high across back-to-back issues. It deasserts the cycle after the final issue handshake, or while the timestamp FIFO is full.
- Record push latency: the record appears at the FIFO output (`rec_valid`=1) one cycle after the completion cycle.
- With `rec_ready` held high, the record FIFO sustains one record per cycle.
- The record FIFO being full deasserts `dut_ap_continue` combinationally from the registered full flag in the same cycle.
- `finish` rises one cycle after the last record is popped.
- With `trans_count`=0, `finish` rises one cycle after `run`.

## Structure
- Package `ap_seq_pkg`: `state_e` enum, the `rec_t` packed struct {index, start, latency}, and the default depth constants.
- One sub-module, `sync_fifo` (parameterised width/depth, registered `full`/`empty`, same-cycle push+pop), instantiated twice: once for timestamps, once for records.

## Test plan
- `trans_count`=3; DUT model asserts ready at start and done 10 cycles later, one transaction at a time; `rec_ready`=1 → 3 records with indices 0,1,2, `rec_latency`=10 each, and `finish` high after the third record.
- Pipelined DUT model: ready every cycle, done 6 cycles after each start, `TS_DEPTH`=4 → `dut_ap_start` drops when 4 transactions are in flight, and no latency other than 6 is ever recorded.
- `rec_ready`=0 with 10 transactions → `dut_ap_continue` goes low after 8 records. Releasing `rec_ready` drains all 10 with correct indices.
- `trans_count`=0 → `finish`=1 one cycle after `run`; `dut_ap_start` never rises.
- Spurious `dut_ap_done` in `IDLE` → `err_unexpected_done`=1 and no record. The flag clears on the next `run`.
- `ap_rst_n` pulsed low mid-`RUN` with 2 transactions in flight → all outputs 0 immediately. A subsequent `run` with `trans_count`=1 produces record index 0.

Source files
------------

// File: rtl/ap_seq_pkg.sv
// Shared types and default sizing for the ap_ctrl_hs transaction sequencer.
package ap_seq_pkg;

  localparam int CNT_W_DEFAULT     = 32;
  localparam int TS_DEPTH_DEFAULT  = 4;
  localparam int REC_DEPTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN,
    DONE
  } state_e;

  // Latency record layout at the default counter width.
  typedef struct packed {
    logic [15:0]              index;
    logic [CNT_W_DEFAULT-1:0] start;
    logic [CNT_W_DEFAULT-1:0] latency;
  } rec_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty and same-cycle push+pop support.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_next;
  logic             do_push;
  logic             do_pop;

  // A push into a full FIFO is only legal when a pop frees the slot in the same cycle.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_next = count;
    if (do_push && !do_pop) begin
      count_next = count + 1'b1;
    end else if (!do_push && do_pop) begin
      count_next = count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count <= count_next;
      full  <= (count_next == FULL_CNT);
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/ap_ctrl_hs_sequencer.sv
// Drives an ap_ctrl_hs DUT for a programmed number of transactions and emits
// one {index, start, latency} record per completed transaction.
module ap_ctrl_hs_sequencer
  import ap_seq_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEFAULT,
  parameter int TS_DEPTH  = TS_DEPTH_DEFAULT,
  parameter int REC_DEPTH = REC_DEPTH_DEFAULT
) (
  input  logic             ap_clk,
  input  logic             ap_rst_n,
  input  logic             run,
  input  logic [15:0]      trans_count,
  output logic             dut_ap_start,
  input  logic             dut_ap_ready,
  input  logic             dut_ap_done,
  output logic             dut_ap_continue,
  output logic             busy,
  output logic             finish,
  output logic             rec_valid,
  input  logic             rec_ready,
  output logic [15:0]      rec_index,
  output logic [CNT_W-1:0] rec_start,
  output logic [CNT_W-1:0] rec_latency,
  output logic             err_unexpected_done
);

  localparam int TS_AW  = $clog2(TS_DEPTH);
  localparam int REC_AW = $clog2(REC_DEPTH);
  localparam int REC_W  = 16 + 2 * CNT_W;
  localparam logic [TS_AW:0] TS_FULL = (TS_AW+1)'(TS_DEPTH);

  state_e           state;
  state_e           state_next;
  logic [CNT_W-1:0] cycle_cnt;
  logic [15:0]      total;
  logic [15:0]      issued;
  logic [15:0]      issued_next;
  logic [15:0]      completed;
  logic             start_q;
  logic             start_next;
  logic             err_q;

  logic             ts_full;
  logic             ts_empty;
  logic [TS_AW:0]   ts_count;
  logic [TS_AW:0]   ts_count_next;
  logic [CNT_W-1:0] ts_head;

  logic             rec_full;
  logic             rec_empty;
  logic [REC_AW:0]  rec_count;
  logic [REC_AW:0]  rec_count_next;
  logic [REC_W-1:0] rec_wdata;
  logic [REC_W-1:0] rec_rdata;

  logic             active;
  logic             run_ok;
  logic             issue;
  logic             completion;
  logic             unexpected;
  logic             rec_pop;

  assign active          = (state == RUN) || (state == DRAIN);
  assign run_ok          = run && ((state == IDLE) || (state == DONE));
  assign dut_ap_start    = start_q;
  assign dut_ap_continue = active && !rec_full;
  assign issue           = (state == RUN) && start_q && dut_ap_ready && !ts_full;
  assign completion      = dut_ap_continue && dut_ap_done && !ts_empty;
  assign unexpected      = dut_ap_done && (!active || ts_empty);
  assign rec_valid       = !rec_empty;
  assign rec_pop         = rec_valid && rec_ready;
  assign busy            = active;
  assign finish          = (state == DONE);
  assign err_unexpected_done = err_q;

  // Latency subtraction wraps naturally, so it stays correct across a counter wrap.
  assign rec_wdata = {completed, ts_head, cycle_cnt - ts_head};
  assign {rec_index, rec_start, rec_latency} = rec_valid ? rec_rdata : '0;

  // Look-ahead occupancies let ap_start be registered yet still drop exactly
  // when the timestamp FIFO fills or the final issue lands.
  always_comb begin
    state_next     = state;
    issued_next    = issued + 16'(issue);
    ts_count_next  = ts_count + (TS_AW+1)'(issue) - (TS_AW+1)'(completion);
    rec_count_next = rec_count + (REC_AW+1)'(completion) - (REC_AW+1)'(rec_pop);
    case (state)
      IDLE, DONE: if (run_ok) state_next = (trans_count == '0) ? DONE : RUN;
      RUN:        if (issued_next == total) state_next = DRAIN;
      DRAIN:      if ((completed == total) && (rec_count_next == '0)) state_next = DONE;
      default:    state_next = IDLE;
    endcase
    start_next = 1'b0;
    if (state_next == RUN) begin
      start_next = run_ok || ((issued_next < total) && (ts_count_next < TS_FULL));
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state     <= IDLE;
      cycle_cnt <= '0;
      total     <= '0;
      issued    <= '0;
      completed <= '0;
      start_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_next;
      cycle_cnt <= cycle_cnt + 1'b1;
      start_q   <= start_next;
      if (run_ok) begin
        total     <= trans_count;
        issued    <= '0;
        completed <= '0;
      end else begin
        if (issue)      issued    <= issued + 1'b1;
        if (completion) completed <= completed + 1'b1;
      end
      if (unexpected) begin
        err_q <= 1'b1;
      end else if (run_ok) begin
        err_q <= 1'b0;
      end
    end
  end

  sync_fifo #(.WIDTH(CNT_W), .DEPTH(TS_DEPTH)) u_ts_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (issue),
    .pop   (completion),
    .wdata (cycle_cnt),
    .rdata (ts_head),
    .full  (ts_full),
    .empty (ts_empty),
    .count (ts_count)
  );

  sync_fifo #(.WIDTH(REC_W), .DEPTH(REC_DEPTH)) u_rec_fifo (
    .clk   (ap_clk),
    .rst_n (ap_rst_n),
    .push  (completion),
    .pop   (rec_pop),
    .wdata (rec_wdata),
    .rdata (rec_rdata),
    .full  (rec_full),
    .empty (rec_empty),
    .count (rec_count)
  );

endmodule

// File: tb/tb_ap_ctrl_hs_sequencer.sv
// Self-checking bench: a behavioural ap_ctrl_hs DUT model plus a queue-based
// reference of the sequencer, compared on every falling clock edge.
module tb_ap_ctrl_hs_sequencer;
  import ap_seq_pkg::*;

  localparam int CNT_W     = 32;
  localparam int TS_DEPTH  = 4;
  localparam int REC_DEPTH = 8;
  localparam int PH_IDLE = 0, PH_RUN = 1, PH_DRAIN = 2, PH_DONE = 3;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n = 1'b1;
  logic             run = 1'b0;
  logic [15:0]      trans_count = '0;
  logic             dut_ap_start;
  logic             dut_ap_ready = 1'b0;
  logic             dut_ap_done = 1'b0;
  logic             dut_ap_continue;
  logic             busy;
  logic             finish;
  logic             rec_valid;
  logic             rec_ready = 1'b1;
  logic [15:0]      rec_index;
  logic [CNT_W-1:0] rec_start;
  logic [CNT_W-1:0] rec_latency;
  logic             err_unexpected_done;

  always #5 ap_clk = ~ap_clk;

  ap_ctrl_hs_sequencer #(.CNT_W(CNT_W), .TS_DEPTH(TS_DEPTH), .REC_DEPTH(REC_DEPTH)) dut (
    .ap_clk              (ap_clk),
    .ap_rst_n            (ap_rst_n),
    .run                 (run),
    .trans_count         (trans_count),
    .dut_ap_start        (dut_ap_start),
    .dut_ap_ready        (dut_ap_ready),
    .dut_ap_done         (dut_ap_done),
    .dut_ap_continue     (dut_ap_continue),
    .busy                (busy),
    .finish              (finish),
    .rec_valid           (rec_valid),
    .rec_ready           (rec_ready),
    .rec_index           (rec_index),
    .rec_start           (rec_start),
    .rec_latency         (rec_latency),
    .err_unexpected_done (err_unexpected_done)
  );

  // Cycle number since reset release, i.e. the timestamp the sequencer should record.
  int unsigned tbCycle;
  always @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) tbCycle <= 0;
    else           tbCycle <= tbCycle + 1;
  end

  int checks = 0;
  int errors = 0;
  int phase = PH_IDLE;
  int mTotal, mIssued, mCompleted;
  bit mErr;
  int unsigned startQ[$];
  int unsigned doneAtQ[$];
  rec_t recQ[$];
  int obsInflight, obsPeak, obsCompleted, popCount;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, tbCycle);
    end
  endtask

  task automatic checkAll();
    bit act;
    act = (phase == PH_RUN) || (phase == PH_DRAIN);
    checkOutput("start", dut_ap_start,
                (phase == PH_RUN) && (mIssued < mTotal) && (startQ.size() < TS_DEPTH));
    checkOutput("continue", dut_ap_continue, act && (recQ.size() < REC_DEPTH));
    checkOutput("busy", busy, act);
    checkOutput("finish", finish, phase == PH_DONE);
    checkOutput("errFlag", err_unexpected_done, mErr);
    checkOutput("recValid", rec_valid, recQ.size() > 0);
    if (recQ.size() > 0) begin
      checkOutput("recIndex", rec_index, recQ[0].index);
      checkOutput("recStart", rec_start, recQ[0].start);
      checkOutput("recLatency", rec_latency, recQ[0].latency);
    end
  endtask

  task automatic applyStimulus(input int n);
    run = 1'b1;
    trans_count = 16'(n);
    dut_ap_ready = 1'b0;
    dut_ap_done = 1'b0;
    @(posedge ap_clk);
    mTotal = n; mIssued = 0; mCompleted = 0; mErr = 0;
    phase = (n == 0) ? PH_DONE : PH_RUN;
    obsInflight = 0; obsPeak = 0; obsCompleted = 0; popCount = 0;
    @(negedge ap_clk);
    run = 1'b0;
  endtask

  // recMode: 0 = always ready, 1 = random, 2 = held low for holdCycles then high.
  task automatic runSequence(input int latMin, input int latMax, input int maxOut,
                             input int readyPct, input int recMode, input int holdCycles,
                             input int expLat, input int abortInflight, input int budget);
    int cyc;
    bit rdy, dn, rr, iss, cmp, pop, act;
    int unsigned st;
    rec_t r;
    cyc = 0;
    while (1) begin
      checkAll();
      if (phase == PH_DONE) break;
      if (abortInflight > 0 && startQ.size() == abortInflight) break;
      if (cyc >= budget) begin
        checks++; errors++;
        $error("[TB] FAIL timeout: observed %0d cycles required below %0d", cyc, budget);
        break;
      end
      rdy = (startQ.size() < maxOut) && ($urandom_range(99) < readyPct);
      dn  = (startQ.size() > 0) && (tbCycle >= doneAtQ[0]);
      case (recMode)
        0:       rr = 1'b1;
        1:       rr = 1'($urandom_range(1));
        default: rr = (cyc >= holdCycles);
      endcase
      if (recMode == 2 && cyc == holdCycles - 1) begin
        checkOutput("continueLowWhenFull", dut_ap_continue, 0);
        checkOutput("completionsWhileHeld", obsCompleted, REC_DEPTH);
      end
      dut_ap_ready = rdy;
      dut_ap_done = dn;
      rec_ready = rr;
      if (dut_ap_start && rdy) obsInflight++;
      if (dut_ap_continue && dn) begin obsInflight--; obsCompleted++; end
      if (obsInflight > obsPeak) obsPeak = obsInflight;
      if (rec_valid && rr) popCount++;
      act = (phase == PH_RUN) || (phase == PH_DRAIN);
      iss = (phase == PH_RUN) && (mIssued < mTotal) && (startQ.size() < TS_DEPTH) && rdy;
      cmp = act && (recQ.size() < REC_DEPTH) && dn;
      pop = (recQ.size() > 0) && rr;
      if (pop) begin
        if (expLat > 0) checkOutput("fixedLatency", rec_latency, expLat);
        void'(recQ.pop_front());
      end
      if (cmp) begin
        st = startQ.pop_front();
        void'(doneAtQ.pop_front());
        r.index = 16'(mCompleted);
        r.start = st;
        r.latency = tbCycle - st;
        recQ.push_back(r);
        mCompleted++;
      end
      if (iss) begin
        startQ.push_back(tbCycle);
        doneAtQ.push_back(tbCycle + $urandom_range(latMax, latMin));
        mIssued++;
      end
      if (phase == PH_RUN && mIssued == mTotal) phase = PH_DRAIN;
      else if (phase == PH_DRAIN && mCompleted == mTotal && recQ.size() == 0) phase = PH_DONE;
      @(posedge ap_clk);
      @(negedge ap_clk);
      cyc++;
    end
    dut_ap_ready = 1'b0;
    dut_ap_done = 1'b0;
  endtask

  task automatic doReset();
    ap_rst_n = 1'b0;
    #1;
    checkOutput("rstStart", dut_ap_start, 0);
    checkOutput("rstContinue", dut_ap_continue, 0);
    checkOutput("rstBusy", busy, 0);
    checkOutput("rstFinish", finish, 0);
    checkOutput("rstRecValid", rec_valid, 0);
    checkOutput("rstRecIndex", rec_index, 0);
    checkOutput("rstRecStart", rec_start, 0);
    checkOutput("rstRecLatency", rec_latency, 0);
    checkOutput("rstErr", err_unexpected_done, 0);
    phase = PH_IDLE; mErr = 0; mTotal = 0; mIssued = 0; mCompleted = 0;
    startQ.delete(); doneAtQ.delete(); recQ.delete();
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  initial begin
    #2;
    doReset();
    checkAll();

    // Spurious done while idle sets the sticky flag without producing a record.
    dut_ap_done = 1'b1;
    @(posedge ap_clk);
    mErr = 1;
    @(negedge ap_clk);
    dut_ap_done = 1'b0;
    checkOutput("spuriousErr", err_unexpected_done, 1);
    checkOutput("spuriousNoRecord", rec_valid, 0);

    // One transaction at a time, done 10 cycles after start.
    applyStimulus(3);
    checkOutput("errClearedByRun", err_unexpected_done, 0);
    runSequence(10, 10, 1, 100, 0, 0, 10, 0, 400);
    checkOutput("seq3Records", popCount, 3);
    checkOutput("seq3Finish", finish, 1);

    // Pipelined DUT: in-flight count must cap at the timestamp depth.
    applyStimulus(12);
    runSequence(6, 6, 8, 100, 0, 0, 6, 0, 400);
    checkOutput("peakInFlight", obsPeak, TS_DEPTH);
    checkOutput("pipeRecords", popCount, 12);

    // Record backpressure: continue drops once the record FIFO holds 8.
    applyStimulus(10);
    runSequence(3, 3, 8, 100, 2, 80, 0, 0, 600);
    checkOutput("backpressureRecords", popCount, 10);

    // Zero-length sequence finishes immediately and never starts the DUT.
    applyStimulus(0);
    checkOutput("zeroFinish", finish, 1);
    repeat (3) begin
      checkOutput("zeroNoStart", dut_ap_start, 0);
      @(negedge ap_clk);
    end

    // Randomised sequences.
    for (int i = 0; i < 5; i++) begin
      int n, lo, hi;
      n  = $urandom_range(12, 1);
      lo = $urandom_range(3, 1);
      hi = lo + $urandom_range(12);
      applyStimulus(n);
      runSequence(lo, hi, $urandom_range(6, 1), $urandom_range(100, 30), 1, 0, 0, 0, 3000);
      checkOutput("randRecords", popCount, n);
    end

    // Reset in the middle of a run with two transactions outstanding.
    applyStimulus(4);
    runSequence(20, 20, 8, 100, 0, 0, 0, 2, 200);
    doReset();
    applyStimulus(1);
    runSequence(4, 4, 1, 100, 0, 0, 4, 0, 100);
    checkOutput("afterResetRecords", popCount, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
